// File: rtl/alu_pkg.sv
// Shared ALU types: FSM state shared by multiplier and divider, Booth digit encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: alu_state_t (IDLE/RUN/DONE), MUL_ITERS, booth_mag_t, booth_digit_t.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  localparam int MUL_ITERS = 16;

  // Radix-4 Booth digit as sign + magnitude; magnitude is 0, 1 or 2 times m.
  typedef enum logic [1:0] {
    MAG_0 = 2'd0,
    MAG_1 = 2'd1,
    MAG_2 = 2'd2
  } booth_mag_t;

  typedef struct packed {
    logic       neg;
    booth_mag_t mag;
  } booth_digit_t;

endpackage

// File: rtl/booth_digit_recoder.sv
// Maps a radix-4 Booth bit triplet {q[2i+1], q[2i], q[2i-1]} to a signed digit.
// Latency: purely combinational.
// Backpressure: none.
// Ports: triplet (3-bit input), digit (booth_digit_t output).
module booth_digit_recoder
  import alu_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  always_comb begin
    digit.neg = 1'b0;
    digit.mag = MAG_0;
    case (triplet)
      3'b001, 3'b010: digit.mag = MAG_1;
      3'b011:         digit.mag = MAG_2;
      3'b100: begin
        digit.neg = 1'b1;
        digit.mag = MAG_2;
      end
      3'b101, 3'b110: begin
        digit.neg = 1'b1;
        digit.mag = MAG_1;
      end
      default: ; // 000 / 111 encode a zero digit
    endcase
  end

endmodule

// File: rtl/booth_mul_32_bit.sv
// Sequential 32x32 signed radix-4 Booth multiplier producing a 64-bit HI/LO product.
// Latency: 16 cycles from the accepting edge to done; one multiply per 18 cycles.
// Backpressure: start is sampled only in IDLE; start and operand changes while busy are ignored.
// Ports: clk, clr (async active-high), start, m, q in; busy, done, hi, lo out (all state-derived).
module booth_mul_32_bit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] m,
  input  logic [31:0] q,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  alu_state_t   state, state_nxt;
  logic [31:0]  m_reg, q_reg;
  logic [63:0]  acc, acc_nxt;
  logic [3:0]   cnt;
  logic         last_iter;

  logic [32:0]  q_ext;
  logic [2:0]   triplet;
  booth_digit_t digit;
  logic [63:0]  m_ext, mag_val, pp;

  // Append the implicit q[-1] = 0 below bit 0 so triplet i starts at bit 2i.
  assign q_ext     = {q_reg, 1'b0};
  assign triplet   = q_ext[{cnt, 1'b0} +: 3];
  assign last_iter = (cnt == 4'(MUL_ITERS - 1));

  booth_digit_recoder u_recoder (
    .triplet (triplet),
    .digit   (digit)
  );

  always_comb begin
    m_ext = {{32{m_reg[31]}}, m_reg};
    case (digit.mag)
      MAG_1:   mag_val = m_ext;
      MAG_2:   mag_val = m_ext << 1;
      default: mag_val = '0;
    endcase
    pp      = digit.neg ? (~mag_val + 64'd1) : mag_val;
    acc_nxt = acc + (pp << {cnt, 1'b0});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      m_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= m;
            q_reg <= q;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
          // Result registers only move on the final iteration so they hold
          // the previous product for the whole run.
          if (last_iter) begin
            hi <= acc_nxt[63:32];
            lo <= acc_nxt[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/booth_mul_32_bit.md
# booth_mul_32_bit

Sequential 32×32 signed multiplier using radix-4 (bit-pair) Booth recoding. It produces a 64-bit two's-complement product split into HI and LO words for the datapath's HI/LO registers. It is the multiply counterpart of the restoring divider in the ALU: the same operand/result widths and the same start/busy/done handshake, so the ALU control unit drives both identically.

## Interface
- No parameters. Width is fixed at 32 bits and the iteration count at 16.
- `clk  in  1`: single clock. All state updates on the rising edge.
- `clr  in  1`: reset, asynchronous and active-high.
- `start  in  1`: request. Sampled only in IDLE.
- `m  in  32`: multiplicand, signed.
- `q  in  32`: multiplier, signed.
- `busy  out  1`: high whenever the state is not IDLE.
- `done  out  1`: one-cycle completion pulse.
- `hi  out  32`: product bits [63:32].
- `lo  out  32`: product bits [31:0].

## Operation
- States:
  - IDLE -> RUN when `start`=1. On that edge, `m` and `q` are latched, the 64-bit accumulator is cleared and the iteration counter is set to 0.
  - RUN -> RUN while counter < 15.
  - RUN -> DONE on the iteration where counter = 15.
  - DONE -> IDLE unconditionally.
- Iteration i (0..15):
  - Triplet is {q[2i+1], q[2i], q[2i−1]}, with q[−1] = 0.
  - Recoded digit: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> −2, 101/110 -> −1.
  - Partial product = digit × m. It is sign-extended to 64 bits, shifted left by 2i, and added to the accumulator modulo 2^64.
  - ±2m is formed by a left shift. −x is formed as ~x + 1. No overflow detection: the full 64-bit product is always exact.
- Result: {`hi`, `lo`} = signed(m) × signed(q).
  - `hi`/`lo` are loaded only on the RUN -> DONE edge.
  - They then hold their value until the next completion or reset. They are not disturbed during RUN.
- `start` while `busy`=1 is ignored, and so are operand changes after the accepting edge.
- `done` = (state == DONE).
- Reset, at any time including mid-RUN: state goes to IDLE immediately and all of these go to 0: `busy`, `done`, `hi`, `lo`, accumulator, counter and latched operands. An aborted operation never produces `done`.

## Timing
- Edge E0 samples `start`=1; `busy` rises after E0.
- Iterations occur on edges E1..E16.
- After E16: `done`=1, and `hi`/`lo` hold the new result.
- After E17: `done`=0, `busy`=0, IDLE.
- Latency is 16 cycles from the accepting edge to `done`. Throughput is one multiply per 18 cycles: `start` held high continuously is next accepted at E18.
- `start` high during the DONE cycle is ignored.
- Reset values of all outputs: 0.
- No combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg`:
  - state enum (IDLE, RUN, DONE), shared with the divider;
  - constant `MUL_ITERS` = 16;
  - the digit encoding type (sign + magnitude 0/1/2).
- One sub-module: `booth_digit_recoder`. It is combinational, maps the 3-bit triplet to the digit encoding, and is instantiated once, driven by a mux on the counter.
- Accumulator, operand latches, counter and FSM live in `booth_mul_32_bit`.

## Test plan
- m=3, q=5, start pulsed one cycle -> `busy` high for E1..E17, `done` one cycle after E16, `hi`=0x00000000, `lo`=0x0000000F.
- m=0xFFFFFFFF (−1), q=1 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFF. Then m=0xFFFFFFFF, q=0xFFFFFFFF -> `hi`=0, `lo`=1.
- m=q=0x80000000 -> `hi`=0x40000000, `lo`=0x00000000. Then m=q=0x7FFFFFFF -> `hi`=0x3FFFFFFF, `lo`=0x00000001.
- m=6, q=7 accepted; at E5 apply start with m=2, q=2 -> ignored, result `lo`=42. `start` held high throughout -> second accept at E18, second `done` 16 edges later.
- Complete m=10, q=10 (`lo`=100). Start m=4, q=4 and assert `clr` mid-cycle at iteration 8 -> outputs 0 immediately (asynchronously), no `done`. After release, m=−7 (0xFFFFFFF9), q=3 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Random signed pairs (≥1000) against a 64-bit reference product. Check that `hi`/`lo` stay stable during RUN and that `done` is exactly one cycle wide.
